// File: rtl/fifo_wr_arbiter.sv
// Write-side controller for the async FIFO: round-robin burst arbitration of
// NREQ requesters onto the single write port, plus idle power-down/wake of power_en.
module fifo_wr_arbiter #(
  parameter int NREQ        = 4,
  parameter int DSIZE       = 8,
  parameter int MAXBURST    = 4,
  parameter int IDLE_LIMIT  = 16,
  parameter int WAKE_CYCLES = 2,
  localparam int IW         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wfull,
  input  logic                  sleep_allow,
  output logic [DSIZE-1:0]      wdata,
  output logic                  winc,
  output logic                  power_en,
  output logic                  grant_valid,
  output logic [IW-1:0]         grant_id,
  output logic                  sleeping
);

  localparam int BW  = $clog2(MAXBURST + 1);
  localparam int IDW = $clog2(IDLE_LIMIT + 1);
  localparam int WW  = $clog2(WAKE_CYCLES + 1);

  localparam logic [BW-1:0]  BEAT_LAST = BW'(MAXBURST - 1);
  localparam logic [IDW-1:0] IDLE_MAX  = IDW'(IDLE_LIMIT);
  localparam logic [IDW-1:0] IDLE_THR  = IDW'(IDLE_LIMIT - 1);
  localparam logic [WW-1:0]  WAKE_LAST = WW'(WAKE_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_SLEEP, S_WAKE} state_t;

  state_t         state_q, state_d;
  logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]  grant_id_q, grant_id_d;
  logic [BW-1:0]  beat_cnt_q, beat_cnt_d;
  logic [IDW-1:0] idle_cnt_q, idle_cnt_d;
  logic [WW-1:0]  wake_cnt_q, wake_cnt_d;
  logic           power_en_q, sleeping_q, grant_valid_q;

  logic           any_valid;
  logic [IW-1:0]  winner;
  logic [IW-1:0]  next_id;
  logic [IW-1:0]  scan_idx;
  logic           fire;
  logic [DSIZE-1:0] slice [NREQ];

  assign any_valid = |req_valid;
  assign next_id   = (grant_id_q == IW'(NREQ - 1)) ? '0 : grant_id_q + 1'b1;

  // Scan downward so the requester closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    winner   = rr_ptr_q;
    scan_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      scan_idx = ((int'(rr_ptr_q) + k) >= NREQ) ? IW'(int'(rr_ptr_q) + k - NREQ)
                                                : IW'(int'(rr_ptr_q) + k);
      if (req_valid[scan_idx]) winner = scan_idx;
    end
  end

  assign fire = (state_q == S_GRANT) && req_valid[grant_id_q] && !wfull && !wrst;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign slice[gi]     = req_data[gi*DSIZE +: DSIZE];
      assign req_ready[gi] = fire && (grant_id_q == IW'(gi));
    end
  endgenerate

  assign wdata       = slice[grant_id_q];
  assign winc        = fire;
  assign power_en    = power_en_q;
  assign sleeping    = sleeping_q;
  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    beat_cnt_d = beat_cnt_q;
    idle_cnt_d = idle_cnt_q;
    wake_cnt_d = wake_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (any_valid) begin
          state_d    = S_GRANT;
          grant_id_d = winner;
          beat_cnt_d = '0;
          idle_cnt_d = '0;
        end else begin
          if (idle_cnt_q != IDLE_MAX) idle_cnt_d = idle_cnt_q + 1'b1;
          if (sleep_allow && (idle_cnt_q >= IDLE_THR)) state_d = S_SLEEP;
        end
      end
      S_GRANT: begin
        if (!req_valid[grant_id_q]) begin
          state_d  = S_IDLE;
          rr_ptr_d = next_id;
        end else if (!wfull) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == BEAT_LAST) begin
            state_d  = S_IDLE;
            rr_ptr_d = next_id;
          end
        end
      end
      S_SLEEP: begin
        if (any_valid) begin
          state_d    = S_WAKE;
          wake_cnt_d = '0;
        end
      end
      S_WAKE: begin
        wake_cnt_d = wake_cnt_q + 1'b1;
        if (wake_cnt_q == WAKE_LAST) begin
          state_d    = S_IDLE;
          idle_cnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they are glitch-free flops.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      grant_id_q    <= '0;
      beat_cnt_q    <= '0;
      idle_cnt_q    <= '0;
      wake_cnt_q    <= '0;
      power_en_q    <= 1'b1;
      sleeping_q    <= 1'b0;
      grant_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      beat_cnt_q    <= beat_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      wake_cnt_q    <= wake_cnt_d;
      power_en_q    <= (state_d != S_SLEEP);
      sleeping_q    <= (state_d == S_SLEEP);
      grant_valid_q <= (state_d == S_GRANT);
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Cycle-by-cycle check of fifo_wr_arbiter against a behavioural model of the
// arbitration, burst and power-down rules, using directed and random stimulus.
module tb_fifo_wr_arbiter;

  localparam int NREQ        = 4;
  localparam int DSIZE       = 8;
  localparam int MAXBURST    = 4;
  localparam int IDLE_LIMIT  = 16;
  localparam int WAKE_CYCLES = 2;
  localparam int IW          = $clog2(NREQ);

  logic                  wclk = 1'b0;
  logic                  wrst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DSIZE-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  wfull;
  logic                  sleep_allow;
  logic [DSIZE-1:0]      wdata;
  logic                  winc;
  logic                  power_en;
  logic                  grant_valid;
  logic [IW-1:0]         grant_id;
  logic                  sleeping;

  fifo_wr_arbiter #(
    .NREQ(NREQ), .DSIZE(DSIZE), .MAXBURST(MAXBURST),
    .IDLE_LIMIT(IDLE_LIMIT), .WAKE_CYCLES(WAKE_CYCLES)
  ) dut (
    .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .wfull(wfull), .sleep_allow(sleep_allow),
    .wdata(wdata), .winc(winc), .power_en(power_en), .grant_valid(grant_valid),
    .grant_id(grant_id), .sleeping(sleeping)
  );

  always #5 wclk = ~wclk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: who owns the port, how many beats it has sent, how long
  // the port has been quiet, and whether the FIFO is asleep or waking.
  bit m_busy, m_asleep, m_waking;
  int m_id, m_start, m_sent, m_quiet, m_wake_left;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_asleep = 0; m_waking = 0;
    m_id = 0; m_start = 0; m_sent = 0; m_quiet = 0; m_wake_left = 0;
  endtask

  task automatic model_edge();
    bit fire;
    if (wrst) begin
      model_reset();
    end else if (m_asleep) begin
      if (req_valid != 0) begin
        m_asleep = 0; m_waking = 1; m_wake_left = WAKE_CYCLES;
      end
    end else if (m_waking) begin
      m_wake_left--;
      if (m_wake_left == 0) begin
        m_waking = 0; m_quiet = 0;
      end
    end else if (m_busy) begin
      fire = req_valid[m_id] && !wfull;
      if (fire) m_sent++;
      if ((fire && m_sent == MAXBURST) || !req_valid[m_id]) begin
        m_busy = 0; m_start = (m_id + 1) % NREQ;
      end
    end else if (req_valid != 0) begin
      for (int i = NREQ - 1; i >= 0; i--)
        if (req_valid[(m_start + i) % NREQ]) m_id = (m_start + i) % NREQ;
      m_busy = 1; m_sent = 0; m_quiet = 0;
    end else begin
      if (m_quiet < 1000) m_quiet++;
      if (sleep_allow && m_quiet >= IDLE_LIMIT) m_asleep = 1;
    end
  endtask

  task automatic check_outputs();
    bit exp_fire;
    logic [NREQ-1:0] exp_ready;
    exp_fire  = m_busy && !wrst && req_valid[m_id] && !wfull;
    exp_ready = '0;
    if (exp_fire) exp_ready[m_id] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    chk("winc", 32'(winc), 32'(exp_fire));
    if (exp_fire) chk("wdata", 32'(wdata), 32'(req_data[m_id*DSIZE +: DSIZE]));
    chk("power_en", 32'(power_en), 32'(!m_asleep));
    chk("sleeping", 32'(sleeping), 32'(m_asleep));
    chk("grant_valid", 32'(grant_valid), 32'(m_busy));
    chk("grant_id", 32'(grant_id), 32'(m_id));
  endtask

  // Fresh data each cycle, check outputs, clock, advance the model.
  task automatic cyc();
    for (int i = 0; i < NREQ; i++) req_data[i*DSIZE +: DSIZE] = DSIZE'($urandom_range(0, 255));
    #1;
    check_outputs();
    @(posedge wclk);
    model_edge();
    #1;
  endtask

  initial begin
    int lat;
    wrst = 1'b1; req_valid = '0; req_data = '0; wfull = 1'b0; sleep_allow = 1'b0;
    @(posedge wclk);
    model_reset();
    #1;
    cyc();
    wrst = 1'b0;

    // Single requester: 4-beat burst, bubble, re-grant.
    req_valid = 4'b0001;
    repeat (12) cyc();

    // All requesting: round-robin 0,1,2,3,0.
    req_valid = 4'b1111;
    repeat (26) cyc();
    req_valid = '0;
    repeat (3) cyc();

    // Requester 2 stalled by wfull after two beats.
    req_valid = 4'b0100;
    repeat (3) cyc();
    wfull = 1'b1;
    repeat (5) cyc();
    wfull = 1'b0;
    repeat (4) cyc();
    req_valid = '0;

    // Idle into SLEEP, then wake on requester 1 and measure request-to-ready latency.
    sleep_allow = 1'b1;
    repeat (20) cyc();
    req_valid = 4'b0010;
    lat = -1;
    for (int n = 0; n < 10; n++) begin
      cyc();
      if (req_ready[1] === 1'b1 && lat < 0) lat = n + 1;
    end
    chk("wake_latency", 32'(lat), 32'(WAKE_CYCLES + 2));
    req_valid = '0;

    // No permission: must stay powered, then sleep once permission arrives.
    sleep_allow = 1'b0;
    repeat (40) cyc();
    chk("no_sleep_power_en", 32'(power_en), 32'd1);
    sleep_allow = 1'b1;
    repeat (3) cyc();
    chk("late_sleep", 32'(sleeping), 32'd1);

    // Reset during beat 3 of a burst.
    req_valid = 4'b1111;
    repeat (6) cyc();
    wrst = 1'b1;
    cyc();
    wrst = 1'b0;
    chk("post_reset_power_en", 32'(power_en), 32'd1);
    chk("post_reset_grant", 32'(grant_valid), 32'd0);
    repeat (6) cyc();

    // Random traffic with quiet stretches so sleep/wake is exercised too.
    for (int n = 0; n < 800; n++) begin
      if ((n % 200) >= 170) begin
        req_valid = '0;
      end else if ($urandom_range(0, 7) == 0) begin
        req_valid = NREQ'($urandom_range(0, 15));
      end
      wfull       = ($urandom_range(0, 4) == 0);
      sleep_allow = ($urandom_range(0, 3) != 0);
      wrst        = ($urandom_range(0, 149) == 0);
      cyc();
    end
    wrst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Write-side controller for the async FIFO.
- Shares the single FIFO write port (wdata/winc, back-pressured by wfull) among NREQ requesters using round-robin burst arbitration.
- Owns the FIFO power_en: drops it after a programmable idle period and re-raises it, with a wake delay, on new traffic.
- Lives entirely in the FIFO write clock domain.

Parameters:
- NREQ, 4, number of requesters (>=2).
- DSIZE, 8, data width; matches the FIFO DSIZE.
- MAXBURST, 4, maximum beats per grant before forced release (>=1).
- IDLE_LIMIT, 16, consecutive idle cycles in IDLE before entering SLEEP (>=1).
- WAKE_CYCLES, 2, cycles power_en is held high in WAKE before arbitration resumes (>=1).

Ports:
- wclk  input  1  write-domain clock; single clock for the whole block. Reset is synchronous and active-high.
- wrst  input  1  synchronous active-high reset.
- req_valid  input  NREQ  per-requester data valid.
- req_data  input  NREQ*DSIZE  packed data; requester i at [i*DSIZE +: DSIZE].
- req_ready  output  NREQ  per-requester accept; a beat transfers when req_valid[i] && req_ready[i].
- wfull  input  1  FIFO full flag.
- sleep_allow  input  1  system permission to power down (read side drained).
- wdata  output  DSIZE  FIFO write data.
- winc  output  1  FIFO write strobe.
- power_en  output  1  FIFO clock-gate enable.
- grant_valid  output  1  high in GRANT state.
- grant_id  output  clog2(NREQ)  current/last granted requester.
- sleeping  output  1  high in SLEEP state.

Behaviour:
- States: IDLE, GRANT, SLEEP, WAKE. All registers update on posedge wclk.
- Reset (wrst=1 at a clock edge): state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0, idle_cnt=0, wake_cnt=0. This gives power_en=1, grant_valid=0, sleeping=0.
- While wrst=1, req_ready and winc are forced to 0 combinationally. Reset mid-burst drops the grant with no further beats.
- IDLE:
  - If any req_valid: winner = first i with req_valid[i], searching cyclically from rr_ptr. Next state is GRANT, grant_id=winner, beat_cnt=0, idle_cnt=0.
  - Otherwise idle_cnt increments, saturating at IDLE_LIMIT.
  - If there is no req_valid, sleep_allow=1, and idle_cnt>=IDLE_LIMIT-1, next state is SLEEP.
  - Request-to-ready latency is 1 cycle.
- GRANT:
  - req_ready[grant_id] = req_valid[grant_id] && !wfull. All other req_ready bits are 0.
  - winc = req_valid[grant_id] && !wfull. wdata = req_data slice grant_id, held in every GRANT cycle.
  - Each transfer increments beat_cnt.
  - Release occurs when a transfer makes beat_cnt reach MAXBURST, or when req_valid[grant_id]=0.
  - On release: next state IDLE, rr_ptr = (grant_id+1) mod NREQ. There is one bubble cycle between grants.
  - wfull=1 stalls: no winc, beat_cnt held, grant kept.
- Outside GRANT: winc=0 and req_ready=0.
- SLEEP:
  - power_en=0, sleeping=1.
  - Any req_valid: next state WAKE, wake_cnt=0. req_valid is ignored for grant purposes here.
  - sleep_allow is not re-checked in SLEEP.
- WAKE:
  - power_en=1. wake_cnt increments.
  - When wake_cnt==WAKE_CYCLES-1, next state IDLE with idle_cnt=0. Arbitration in IDLE then sees the pending request.
  - Total latency from req_valid in SLEEP to first req_ready is WAKE_CYCLES+2 cycles.
- power_en is a registered state decode: 0 only in SLEEP. Glitch-free.
- grant_id holds its last value outside GRANT.
- Widths: beat_cnt is clog2(MAXBURST+1) bits, idle_cnt is clog2(IDLE_LIMIT+1) bits, wake_cnt is clog2(WAKE_CYCLES+1) bits. rr_ptr wraps NREQ-1 -> 0.
- Simultaneous events:
  - A final-beat transfer with wfull rising in the same cycle: the transfer counts, because wfull is sampled as the current input.
  - wrst has priority over every transition.

Test Plan:
- Reset, req_valid=4'b0001, wfull=0 -> req_ready[0] rises 1 cycle later; 4 beats written (winc=1 for 4 cycles); release; IDLE bubble; re-grant to 0.
- req_valid=4'b1111 held, MAXBURST=4 -> grant order 0,1,2,3,0; 4 beats each; one bubble cycle between grants; wdata matches each granted slice.
- Granted requester 2, wfull=1 for 5 cycles mid-burst after beat 2 -> winc=0 and req_ready=0 during the stall; beat_cnt holds at 2; 2 more beats follow once wfull=0; then release.
- No requests, sleep_allow=1, IDLE_LIMIT=16 -> power_en falls after 16 idle cycles, sleeping=1. Then req_valid[1]=1 -> power_en=1 the next cycle; req_ready[1] rises WAKE_CYCLES+2=4 cycles after req_valid.
- sleep_allow=0 with 40 idle cycles -> power_en stays 1. Set sleep_allow=1 -> SLEEP entered on the next idle cycle.
- wrst asserted during beat 3 of a burst -> req_ready=0 and winc=0 in that cycle; post-reset state IDLE, power_en=1, rr_ptr=0.
